spi_master_core: RTL
====================

# spi_master_core

Tick-driven SPI mode-0 master engine that consumes the single-cycle enable strobe produced by the clock-divider stage and turns it into SCLK edges. It serialises one `DATA_WIDTH` word on MOSI while capturing MISO, under a start/busy/done handshake with the controlling logic. The divider sets the bit rate; this block owns chip-select, framing and the shift registers.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per frame; legal range 2..32.
- `CNT_WIDTH`, default 6: bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- `in_clock` in 1: system clock; all logic on its rising edge.
- `in_reset_n` in 1: asynchronous, active-low reset.
- `in_tick` in 1: one-`in_clock`-wide strobe from the divider; one SCLK half-period per tick.
- `in_start` in 1: request a frame; accepted only while `out_busy`=0.
- `in_tx_data` in DATA_WIDTH: word to send; latched on start acceptance.
- `in_miso` in 1: serial data from the slave.
- `out_rx_data` out DATA_WIDTH: last received word; updated only at frame end.
- `out_busy` out 1: high from the cycle after acceptance until frame end.
- `out_done` out 1: one-cycle pulse at frame end.
- `out_sclk` out 1: SPI clock, idles low.
- `out_mosi` out 1: SPI data out.
- `out_cs_n` out 1: chip select, active low.

## Operation
- Reset values: `out_sclk`=0, `out_cs_n`=1, `out_mosi`=0, `out_busy`=0, `out_done`=0, `out_rx_data`=0, state IDLE, counter 0.
- Mode 0: CPOL=0, CPHA=0; MISO sampled on SCLK rising edge; MOSI changes on SCLK falling edge.
- FSM states:
  - IDLE: `in_start`=1 -> latch `in_tx_data`, drive `out_cs_n`=0, `out_mosi`=first bit, `out_busy`=1, go SETUP. `in_tick` is ignored.
  - SETUP: wait for one tick, then go SHIFT. This provides the CS-to-SCLK setup time.
  - SHIFT: each tick toggles `out_sclk`.
    - On a 0->1 toggle: shift `in_miso` into the rx register and increment the counter.
    - On a 1->0 toggle: if counter < DATA_WIDTH, present the next tx bit; else go HOLD with `out_sclk`=0.
  - HOLD: on the next tick set `out_cs_n`=1, `out_mosi`=0, copy rx shift register to `out_rx_data`, `out_busy`=0, `out_done`=1, go IDLE.
- `out_done` stays high for exactly one `in_clock` cycle.
- A start request in the `out_done` cycle is accepted, giving back-to-back frames with a minimum CS-high gap of 1 `in_clock`.
- `in_start` while busy is ignored and is not queued.
- `in_tx_data` changes after acceptance have no effect on the frame in progress.
- Async reset mid-frame: all outputs go to reset values immediately; the partial frame is discarded; `out_done` does not pulse.

## Timing
- Acceptance: `out_busy`/`out_cs_n` change on the clock edge that samples `in_start`=1 in IDLE.
- Frame length is DATA_WIDTH+... ticks after acceptance, precisely 2·DATA_WIDTH+2 ticks: 1 SETUP, 2·DATA_WIDTH SHIFT, 1 HOLD.
- All outputs are registered; every SCLK edge aligns to the `in_clock` edge where `in_tick`=1.
- `in_tick` must be spaced at least 2 `in_clock` cycles apart. A tick every cycle is out of spec.

## Configuration
- `SPI_LSB_FIRST_EN` defined: tx and rx are LSB-first. `in_tx_data[0]` goes out first, and the first received bit lands in `out_rx_data[0]`.
- Undefined (default): MSB-first. `in_tx_data[DATA_WIDTH-1]` goes out first, and the first received bit lands in `out_rx_data[DATA_WIDTH-1]`.

## Structure
- Package `spi_pkg` holds:
  - the state typedef `spi_state_t` (IDLE, SETUP, SHIFT, HOLD);
  - the CPOL/CPHA constants (0/0);
  - the idle levels for SCLK, CS_n and MOSI.
- One sub-module, `spi_shift_reg`: a parallel-load, serial-in/serial-out register with shift-enable and direction set by `SPI_LSB_FIRST_EN`.
- The FSM and bit counter stay in `spi_master_core`.

## Test plan
All scenarios use DATA_WIDTH=8 and `in_tick` every 4 clocks unless noted.
- MOSI looped to MISO, tx=0xA5, MSB-first -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; `out_rx_data`=0xA5; `out_done` pulses once, 18 ticks after acceptance.
- Slave drives a fixed 0x3C, tx=0xFF -> `out_rx_data`=0x3C; exactly 8 SCLK rising edges while `out_cs_n`=0.
- `in_start` pulsed with tx=0x11 during an active frame of 0x5A -> ignored; only 0x5A appears on MOSI; one `out_done` pulse.
- `in_start` held high through `out_done` -> a second frame starts with `out_cs_n` high for exactly 1 `in_clock`.
- `in_reset_n` pulled low at the 4th SCLK rising edge -> `out_cs_n`=1, `out_sclk`=0, `out_busy`=0 immediately; no `out_done`; `out_rx_data`=0.
- With `SPI_LSB_FIRST_EN` defined and loopback, tx=0x01 -> first MOSI bit 1, remaining bits 0; `out_rx_data`=0x01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master core.
//   spi_state_t : frame FSM states (idle, CS setup, shifting, CS hold)
//   SpiCpol/SpiCpha : fixed SPI mode 0
//   SclkIdle/CsNIdle/MosiIdle : line levels when no frame is active
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_t;

  localparam logic SpiCpol  = 1'b0;
  localparam logic SpiCpha  = 1'b0;

  localparam logic SclkIdle = SpiCpol;
  localparam logic CsNIdle  = 1'b1;
  localparam logic MosiIdle = 1'b0;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register shared by TX and RX.
// Each shift pushes serial_i in at one end while the next TX bit appears
// on serial_o, so after Width shifts the register holds the received word.
// Direction: MSB-first by default, LSB-first when SPI_LSB_FIRST_EN is defined.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   load_i         : load load_data_i (has priority over shift_i)
//   shift_i        : shift one position, inserting serial_i
//   serial_o       : bit currently at the output end
//   data_o         : full register contents
module spi_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_q, data_d;
  logic [Width-1:0] shifted;

`ifdef SPI_LSB_FIRST_EN
  assign shifted  = {serial_i, data_q[Width-1:1]};
  assign serial_o = data_q[0];
`else
  assign shifted  = {data_q[Width-2:0], serial_i};
  assign serial_o = data_q[Width-1];
`endif

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master_core.sv
// Tick-driven SPI mode-0 master. Each in_tick is one SCLK half-period; the
// block frames one DATA_WIDTH word with chip-select, shifting MOSI out and
// MISO in. A frame is 1 setup tick, 2*DATA_WIDTH shift ticks, 1 hold tick.
// Bit order: MSB-first by default, LSB-first when SPI_LSB_FIRST_EN is defined.
// Ports:
//   in_clock, in_reset_n : clock, async active-low reset
//   in_tick              : divider strobe, one clock wide
//   in_start, in_tx_data : frame request and word, taken only when not busy
//   in_miso              : serial data from the slave
//   out_rx_data          : last received word, updated at frame end
//   out_busy, out_done   : frame in progress / one-cycle end-of-frame pulse
//   out_sclk, out_mosi, out_cs_n : SPI lines (all registered)
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_tick,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_tx_data,
  input  logic                  in_miso,
  output logic [DATA_WIDTH-1:0] out_rx_data,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_sclk,
  output logic                  out_mosi,
  output logic                  out_cs_n
);

  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DATA_WIDTH);

  spi_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  logic                  accept;
  logic                  capture;
  logic                  first_bit;
  logic                  all_bits;
  logic                  sr_serial;
  logic [DATA_WIDTH-1:0] sr_data;

  assign accept = (state_q == StIdle) && in_start;

  // Capture happens when SCLK is about to leave the level CPOL^CPHA; for
  // mode 0 that is the 0->1 toggle.
  assign capture = (state_q == StShift) && in_tick && (sclk_q == (SpiCpol ^ SpiCpha));

  assign all_bits = (cnt_q >= CntFull);

`ifdef SPI_LSB_FIRST_EN
  assign first_bit = in_tx_data[0];
`else
  assign first_bit = in_tx_data[DATA_WIDTH-1];
`endif

  // One register carries both directions: a capture shifts MISO in and
  // exposes the next TX bit, which the following falling edge drives out.
  spi_shift_reg #(
    .Width (DATA_WIDTH)
  ) u_shift_reg (
    .clk_i       (in_clock),
    .rst_ni      (in_reset_n),
    .load_i      (accept),
    .load_data_i (in_tx_data),
    .shift_i     (capture),
    .serial_i    (in_miso),
    .serial_o    (sr_serial),
    .data_o      (sr_data)
  );

  // State register and all output/datapath flops.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sclk_q    <= SclkIdle;
      cs_n_q    <= CsNIdle;
      mosi_q    <= MosiIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_start) state_d = StSetup;
      StSetup: if (in_tick) state_d = StShift;
      StShift: if (in_tick && (sclk_q != SclkIdle) && all_bits) state_d = StHold;
      StHold:  if (in_tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          cs_n_d = 1'b0;
          mosi_d = first_bit;
          busy_d = 1'b1;
          cnt_d  = '0;
        end
      end
      StSetup: ;
      StShift: begin
        if (in_tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q == SclkIdle) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (!all_bits) begin
            mosi_d = sr_serial;
          end else begin
            sclk_d = SclkIdle;
          end
        end
      end
      StHold: begin
        if (in_tick) begin
          cs_n_d    = CsNIdle;
          mosi_d    = MosiIdle;
          rx_data_d = sr_data;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_rx_data = rx_data_q;
  assign out_busy    = busy_q;
  assign out_done    = done_q;
  assign out_sclk    = sclk_q;
  assign out_mosi    = mosi_q;
  assign out_cs_n    = cs_n_q;

endmodule
